// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data cache memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_e;

  localparam int unsigned WORD_BYTES_LOG2 = 2;

  // Byte-offset bits covered by one line burst of word-sized beats.
  function automatic int unsigned line_off_bits(input int unsigned beats);
    return $clog2(beats) + WORD_BYTES_LOG2;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the icache, bit 1 the dcache.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  gnt_e last_q;

  // On a tie the requester not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == GNT_DC) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= GNT_DC;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1] ? GNT_DC : GNT_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one burst memory port between icache refills and dcache refill/writeback,
// and raises the CPU pipeline stall while any cache is waiting or being served.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic              dc_rvalid,
  output logic              dc_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_cmd_we,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int unsigned       CNT_W     = $clog2(BEATS);
  localparam int unsigned       OFF_W     = line_off_bits(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  state_e            state_q;
  gnt_e              gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cmd_valid_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic              cmd_we_q;
  logic              wdata_valid_q;
  logic              ic_ack_q;
  logic              dc_ack_q;

  logic [1:0]        arb_gnt;
  logic              arb_advance;
  logic              wr_beat;
  logic              rd_beat;
  logic              beat_acc;

  assign arb_advance = (state_q == IDLE) && (ic_req || dc_req);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({dc_req, ic_req}),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  // Beats move only in their own data phase; stray read valids elsewhere are dropped.
  assign wr_beat  = (state_q == WDATA) && mem_wdata_ready;
  assign rd_beat  = (state_q == RDATA) && mem_rdata_valid;
  assign beat_acc = wr_beat || rd_beat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      gnt_q         <= GNT_IC;
      cnt_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_we_q      <= 1'b0;
      wdata_valid_q <= 1'b0;
      ic_ack_q      <= 1'b0;
      dc_ack_q      <= 1'b0;
    end else begin
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_advance) begin
            state_q     <= CMD;
            cmd_valid_q <= 1'b1;
            cnt_q       <= '0;
            if (arb_gnt[1]) begin
              gnt_q      <= GNT_DC;
              cmd_addr_q <= dc_addr & LINE_MASK;
              cmd_we_q   <= dc_we;
            end else begin
              gnt_q      <= GNT_IC;
              cmd_addr_q <= ic_addr & LINE_MASK;
              cmd_we_q   <= 1'b0;
            end
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            if (cmd_we_q) begin
              state_q       <= WDATA;
              wdata_valid_q <= 1'b1;
            end else begin
              state_q <= RDATA;
            end
          end
        end
        WDATA, RDATA: begin
          if (beat_acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q       <= DONE;
              wdata_valid_q <= 1'b0;
              ic_ack_q      <= (gnt_q == GNT_IC);
              dc_ack_q      <= (gnt_q == GNT_DC);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_cmd_valid   = cmd_valid_q;
  assign mem_cmd_addr    = cmd_addr_q;
  assign mem_cmd_we      = cmd_we_q;
  assign mem_wdata_valid = wdata_valid_q;
  assign mem_wdata       = dc_wdata;
  assign ic_ack          = ic_ack_q;
  assign dc_ack          = dc_ack_q;

  assign dc_wnext  = wr_beat;
  assign ic_rvalid = rd_beat && (gnt_q == GNT_IC);
  assign dc_rvalid = rd_beat && (gnt_q == GNT_DC);
  assign rdata     = mem_rdata;

  assign stall = (state_q != IDLE) || ic_req || dc_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference checked every cycle.
module tb_mem_arbiter;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((1 << ($clog2(BEATS) + 2)) - 1));

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rvalid, ic_ack;
  logic              dc_req, dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_wnext, dc_rvalid, dc_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_cmd_valid, mem_cmd_ready;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic              mem_cmd_we;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  mem_arbiter #(.BEATS(BEATS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_ack(dc_ack), .rdata(rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_we(mem_cmd_we),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: burst memory responder and dcache write-beat source
  bit                rd_active = 1'b0;
  int                rd_idx    = 0;
  logic [DATA_W-1:0] rd_base   = '0;
  logic [DATA_W-1:0] wbase     = '0;
  int                wbeat     = 0;
  bit                force_rvalid = 1'b0, wready_toggle = 1'b0;
  bit                ic_repeat = 1'b0, dc_repeat = 1'b0;

  // Reference: one transaction at a time, phases cmd -> data -> ack
  bit                m_cmd = 1'b0, m_data = 1'b0, m_ack = 1'b0;
  bit                m_we = 1'b0, m_owner_dc = 1'b0, m_last_dc = 1'b1;
  int                m_left = 0;
  logic [ADDR_W-1:0] m_addr = '0;

  // Observed-event logs for the literal expectations
  logic [DATA_W-1:0] ic_rd_q[$];
  logic [DATA_W-1:0] wr_q[$];
  logic [ADDR_W-1:0] cmd_addr_log[$];
  bit                cmd_we_log[$];
  int ic_ack_n = 0, dc_ack_n = 0, ic_ack_cyc = 0, dc_ack_cyc = 0;
  int ic_rv_n = 0, dc_rv_n = 0, last_wnext_cyc = 0;
  bit prev_cmd_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit busy, dw, dr;
    busy = m_cmd | m_data | m_ack;
    dw   = m_data & m_we;
    dr   = m_data & !m_we;
    chk("stall", stall, busy | ic_req | dc_req);
    chk("cmd_valid", mem_cmd_valid, m_cmd);
    if (m_cmd) begin
      chk("cmd_addr", mem_cmd_addr, m_addr);
      chk("cmd_we", mem_cmd_we, m_we);
    end
    chk("wdata_valid", mem_wdata_valid, dw);
    chk("dc_wnext", dc_wnext, dw & mem_wdata_ready);
    chk("ic_rvalid", ic_rvalid, dr & !m_owner_dc & mem_rdata_valid);
    chk("dc_rvalid", dc_rvalid, dr & m_owner_dc & mem_rdata_valid);
    chk("ic_ack", ic_ack, m_ack & !m_owner_dc);
    chk("dc_ack", dc_ack, m_ack & m_owner_dc);
    chk("rdata", rdata, mem_rdata);
    chk("mem_wdata", mem_wdata, dc_wdata);

    if (mem_cmd_valid === 1'b1 && !prev_cmd_valid) begin
      cmd_addr_log.push_back(mem_cmd_addr);
      cmd_we_log.push_back(mem_cmd_we);
    end
    prev_cmd_valid = (mem_cmd_valid === 1'b1);
    if (ic_rvalid === 1'b1) begin ic_rd_q.push_back(rdata); ic_rv_n++; end
    if (dc_rvalid === 1'b1) dc_rv_n++;
    if (dc_wnext === 1'b1) begin wr_q.push_back(mem_wdata); last_wnext_cyc = cyc; end
    if (ic_ack === 1'b1) begin ic_ack_n++; ic_ack_cyc = cyc; end
    if (dc_ack === 1'b1) begin dc_ack_n++; dc_ack_cyc = cyc; end

    // Advance the reference to the state after the coming rising edge
    if (!rst) begin
      m_cmd = 0; m_data = 0; m_ack = 0; m_we = 0; m_last_dc = 1; m_addr = '0;
    end else if (m_ack) begin
      m_ack = 0;
    end else if (m_cmd) begin
      if (mem_cmd_ready) begin m_cmd = 0; m_data = 1; m_left = BEATS; end
    end else if (m_data) begin
      if (m_we ? mem_wdata_ready : mem_rdata_valid) begin
        m_left--;
        if (m_left == 0) begin m_data = 0; m_ack = 1; end
      end
    end else if (ic_req || dc_req) begin
      m_owner_dc = (ic_req && dc_req) ? !m_last_dc : dc_req;
      m_last_dc  = m_owner_dc;
      m_addr     = (m_owner_dc ? dc_addr : ic_addr) & LINE_MASK;
      m_we       = m_owner_dc & dc_we;
      m_cmd      = 1;
    end
  end

  // One clock: the environment reacts to handshakes completed at this edge
  task automatic step();
    bit cmd_rd_acc, beat_out, wr_acc;
    cmd_rd_acc = (mem_cmd_valid === 1'b1) && mem_cmd_ready && (mem_cmd_we === 1'b0);
    beat_out   = rd_active;
    wr_acc     = (mem_wdata_valid === 1'b1) && mem_wdata_ready;
    @(posedge clk);
    #1;
    if (beat_out) begin
      rd_idx++;
      if (rd_idx == BEATS) rd_active = 0;
    end
    if (cmd_rd_acc) begin rd_active = 1; rd_idx = 0; end
    if (wr_acc) wbeat++;
    if (ic_ack === 1'b1 && !ic_repeat) ic_req = 0;
    if (dc_ack === 1'b1 && !dc_repeat) dc_req = 0;
    if (wready_toggle) mem_wdata_ready = !mem_wdata_ready;
    mem_rdata_valid = rd_active | force_rvalid;
    mem_rdata       = rd_base + DATA_W'(rd_idx);
    dc_wdata        = wbase + DATA_W'(wbeat);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((ic_req || dc_req || stall || rd_active) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic clear_logs();
    ic_rd_q.delete(); wr_q.delete(); cmd_addr_log.delete(); cmd_we_log.delete();
    ic_ack_n = 0; dc_ack_n = 0; ic_rv_n = 0; dc_rv_n = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_cmd_valid"}, mem_cmd_valid, 0);
    chk({tag, "_cmd_addr"}, mem_cmd_addr, 0);
    chk({tag, "_cmd_we"}, mem_cmd_we, 0);
    chk({tag, "_wdata_valid"}, mem_wdata_valid, 0);
    chk({tag, "_ic_ack"}, ic_ack, 0);
    chk({tag, "_dc_ack"}, dc_ack, 0);
    chk({tag, "_ic_rvalid"}, ic_rvalid, 0);
  endtask

  initial begin
    int req_cyc;
    rst = 0; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0;
    dc_wdata = '0; mem_cmd_ready = 1; mem_wdata_ready = 0;
    mem_rdata_valid = 0; mem_rdata = '0;

    repeat (3) step();
    chk_outputs_zero("reset");
    rst = 1;
    step();

    // Single icache refill, zero-wait memory
    clear_logs();
    rd_base = 32'hA0; ic_addr = 32'h0000_1234; ic_req = 1; req_cyc = cyc;
    wait_idle(40);
    chk("t1_cmd_addr", cmd_addr_log[0], 32'h0000_1230);
    chk("t1_cmd_we", cmd_we_log[0], 0);
    chk("t1_ic_beats", ic_rd_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_ic_rdata", ic_rd_q[i], 32'hA0 + i);
    chk("t1_ack_latency", ic_ack_cyc - req_cyc, 6);
    chk("t1_ic_ack_count", ic_ack_n, 1);
    chk("t1_dc_rvalid", dc_rv_n, 0);

    // dcache writeback with write-ready toggling
    clear_logs();
    wbase = 32'hD0; wbeat = 0; dc_wdata = 32'hD0; wready_toggle = 1; mem_wdata_ready = 1;
    dc_addr = 32'h1000_0040; dc_we = 1; dc_req = 1;
    wait_idle(60);
    wready_toggle = 0; mem_wdata_ready = 0;
    chk("t2_cmd_addr", cmd_addr_log[0], 32'h1000_0040);
    chk("t2_cmd_we", cmd_we_log[0], 1);
    chk("t2_wnext_count", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_wdata", wr_q[i], 32'hD0 + i);
    chk("t2_ack_after_last", dc_ack_cyc - last_wnext_cyc, 1);
    chk("t2_dc_ack_count", dc_ack_n, 1);

    // Both requesting from reset, continuously: IC, DC, IC, DC
    rst = 0; step(); step(); rst = 1;
    clear_logs();
    rd_base = 32'h50; dc_we = 0;
    ic_addr = 32'h0000_5004; dc_addr = 32'h0000_6008;
    ic_repeat = 1; dc_repeat = 1; ic_req = 1; dc_req = 1;
    for (int n = 0; n < 80 && cmd_addr_log.size() < 4; n++) step();
    ic_repeat = 0; dc_repeat = 0;
    wait_idle(80);
    chk("t3_grant0", cmd_addr_log[0], 32'h0000_5000);
    chk("t3_grant1", cmd_addr_log[1], 32'h0000_6000);
    chk("t3_grant2", cmd_addr_log[2], 32'h0000_5000);
    chk("t3_grant3", cmd_addr_log[3], 32'h0000_6000);

    // Command back-pressure for five cycles
    clear_logs();
    mem_cmd_ready = 0; ic_addr = 32'h2000_0018; ic_req = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_cmd_valid", mem_cmd_valid, 1);
      chk("t4_cmd_addr", mem_cmd_addr, 32'h2000_0010);
      chk("t4_cmd_we", mem_cmd_we, 0);
      chk("t4_stall", stall, 1);
    end
    mem_cmd_ready = 1;
    wait_idle(40);
    chk("t4_ic_ack_count", ic_ack_n, 1);

    // Reset during the second read beat
    clear_logs();
    rd_base = 32'hB0; ic_addr = 32'h3000_0000; ic_req = 1;
    repeat (3) step();
    rst = 0; ic_req = 0;
    step();
    chk_outputs_zero("t5");
    rst = 1;
    repeat (6) step();
    chk("t5_no_ack", ic_ack_n + dc_ack_n, 0);
    chk("t5_beats_before_reset", ic_rd_q.size(), 2);
    wait_idle(20);

    // Spurious read-valid while idle and during a writeback
    clear_logs();
    force_rvalid = 1;
    repeat (2) step();
    wbase = 32'hE0; wbeat = 0; dc_wdata = 32'hE0; mem_wdata_ready = 1;
    dc_addr = 32'h4000_0080; dc_we = 1; dc_req = 1; req_cyc = cyc;
    wait_idle(40);
    force_rvalid = 0; mem_wdata_ready = 0;
    step();
    chk("t6_no_rvalid", ic_rv_n + dc_rv_n, 0);
    chk("t6_wnext_count", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6_wdata", wr_q[i], 32'hE0 + i);
    chk("t6_ack_latency", dc_ack_cyc - req_cyc, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
